// File: rtl/adder_serial_responder.sv
// Bit-serial ripple-carry adder with valid/ready operand and sum channels.
// It resolves one full-adder stage per clock, LSB first, and returns a (WIDTH+1)-bit sum.
module adder_serial_responder #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH:0]   sum_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s_d, carry_d;
  logic [WIDTH-1:0] a_d, b_d, res_d;

  // One full-adder stage on the current LSBs; the sum bit enters the result from the top.
  always_comb begin
    s_d          = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d      = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    a_d          = a_q >> 1;
    b_d          = b_q >> 1;
    res_d        = res_q >> 1;
    res_d[WIDTH-1] = s_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= x;
            b_q        <= y;
            res_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ADD;
          end
        end
        ADD: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            sum_q       <= {carry_d, res_d};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // sum_q is only written in ADD, so it stays stable under backpressure.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign busy      = busy_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_adder_serial_responder.sv
// Scoreboard bench for adder_serial_responder: the driver queues expected sums and
// a negedge monitor pops and checks them on every output handshake.
module tb_adder_serial_responder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] x, y;
  logic [3:0] sum;
  logic [7:0] op_count;

  adder_serial_responder #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  logic [3:0] sb[$];
  logic [7:0] exp_cnt = 8'd0;
  int         npass = 0, ntot = 0;
  time        t_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    ntot++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [2:0] xv, input logic [2:0] yv, input logic [3:0] e);
    int n = 0;
    in_valid = 1'b1; x = xv; y = yv;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) fail("accept_timeout");
    else begin
      sb.push_back(e);
      @(posedge clk); t_acc = $time;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0 || out_valid) fail("drain_timeout");
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) fail("extra_output");
      else chk("sum", sum, sb.pop_front());
      chk("op_count_at_handshake", op_count, exp_cnt);
      exp_cnt = exp_cnt + 8'd1;
    end
  end

  initial begin
    time t1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_sum", sum, 0); chk("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive 3-bit operands
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        send(3'(i), 3'(j), 4'(i + j));
    wait_idle();
    chk("exhaustive_count", op_count, 64);

    // Carry extremes
    send(3'd7, 3'd7, 4'b1110);
    send(3'd7, 3'd1, 4'b1000);
    send(3'd0, 3'd0, 4'b0000);
    wait_idle();

    // Latency: out_valid first high after E3
    send(3'd1, 3'd2, 4'd3);
    chk("lat_e0_valid", out_valid, 0); chk("lat_e0_busy", busy, 1);
    @(negedge clk); chk("lat_e1_valid", out_valid, 0);
    @(negedge clk); chk("lat_e2_valid", out_valid, 0);
    @(negedge clk); chk("lat_e3_valid", out_valid, 1);
    wait_idle();
    send(3'd3, 3'd3, 4'd6); t1 = t_acc;
    send(3'd2, 3'd5, 4'd7);
    chk("b2b_period", 32'(t_acc - t1), 50);
    wait_idle();

    // Backpressure
    out_ready = 1'b0;
    send(3'd5, 3'd6, 4'd11);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", out_valid, 1); chk("bp_sum", sum, 11); chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released_valid", out_valid, 0); chk("bp_released_ready", in_ready, 1);
    chk("bp_count", op_count, 32'(exp_cnt));

    // in_valid pulsed while busy is ignored
    send(3'd3, 3'd4, 4'd7);
    in_valid = 1'b1; x = 3'd5; y = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
    chk("ignore_valid", out_valid, 0); chk("ignore_busy", busy, 0);
    chk("ignore_count", op_count, 32'(exp_cnt));

    // Async reset mid-ADD
    send(3'd2, 3'd2, 4'd4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0); chk("arst_in_ready", in_ready, 1);
    chk("arst_op_count", op_count, 0); chk("arst_busy", busy, 0);
    sb.delete(); exp_cnt = 8'd0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    send(3'd6, 3'd1, 4'd7);
    wait_idle();
    chk("post_rst_count", op_count, 1);

    // Counter wrap: 255 more completions bring it to 256 -> 0
    for (int i = 0; i < 255; i++)
      send(3'(i % 8), 3'((i / 8) % 8), 4'((i % 8) + ((i / 8) % 8)));
    wait_idle();
    chk("wrap_count", op_count, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
